ras_stack: RTL
==============

# ras_stack

Return address stack for the fetch stage. It consumes the per-bundle RAS command and branch PC from the fetch branch decoder. It supplies the predicted return target back to that decoder's `ras_data_i` input. It also checkpoints its pointer state so the backend can repair it after a branch mispredict.

## Interface
Parameters:
- `DEPTH`, 8: number of entries; must be a power of 2, at least 2.
- `PW`, log2(DEPTH): pointer width (derived).
- `CKW`, 2*PW+1: checkpoint width, packed as {count[PW:0], tos[PW-1:0]} (derived).

Ports:
- `clk_i`, input, 1: clock. One clock; all state changes on its rising edge.
- `rst_i`, input, 1: reset. Asynchronous, active-high.
- `ras_valid_i`, input, 1: the command is valid this cycle. Fetch asserts it only when the bundle advances and a branch exists.
- `ras_ctrl_i`, input, 2: command. 00 = none, 01 = push (call), 10 = pop (return), 11 = pop-then-push (coroutine).
- `ras_pc_i`, input, 64: PC of the call instruction. The stored value is `ras_pc_i + 4`.
- `recover_i`, input, 1: restore the pointer state from `recover_ckpt_i`.
- `recover_ckpt_i`, input, CKW: checkpoint captured earlier from `ras_ckpt_o`.
- `ras_top_o`, output, 64: predicted return target, equal to mem[tos]. Combinational from state. Feeds the decoder's `ras_data_i`.
- `ras_empty_o`, output, 1: count == 0.
- `ras_ckpt_o`, output, CKW: current {count, tos}, before this cycle's command. Travels with the bundle.
- `ras_underflow_o`, output, 1: registered one-cycle pulse when a pop hits an empty stack.

## Operation
State:
- mem[DEPTH] of 64 bits.
- `tos`: PW bits, index of the top valid entry.
- `count`: PW+1 bits, range 0..DEPTH.

Commands are executed only when `ras_valid_i` = 1. Ctrl 00, or valid = 0, leaves state unchanged.

- **Push:**
  - mem[tos+1] <= ras_pc_i + 4.
  - tos <= tos+1, wrapping modulo DEPTH.
  - count <= min(count+1, DEPTH).
  - When full, the push silently overwrites the oldest entry.
- **Pop:**
  - If count > 0: tos <= tos-1 (modulo DEPTH), count <= count-1.
  - If count == 0: tos and count are unchanged, and `ras_underflow_o` pulses next cycle.
  - Memory is not cleared by a pop.
- **Pop-then-push:**
  - mem[tos] <= ras_pc_i + 4; tos unchanged.
  - count <= (count == 0) ? 1 : count. No underflow pulse.
- **Recover:**
  - {count, tos} <= recover_ckpt_i.
  - Memory is not restored; entries overwritten on the wrong path stay corrupted.
  - Recover has priority: when `recover_i` = 1, any simultaneous valid command is dropped.
- The `ras_pc_i + 4` addition is 64-bit, wrapping modulo 2^64.
- `ras_top_o` is mem[tos] even when the stack is empty. The consumer qualifies it with `ras_empty_o`.

## Timing
- Reset, asynchronous: tos = 0, count = 0, all mem entries = 0. This gives `ras_top_o` = 0, `ras_empty_o` = 1, `ras_ckpt_o` = 0, `ras_underflow_o` = 0.
  - Reset asserted mid-operation discards any command in flight.
  - Outputs take reset values immediately, not at the next edge.
- Latency: a command presented in cycle N updates state at the edge ending N. `ras_top_o`, `ras_empty_o` and `ras_ckpt_o` reflect it in cycle N+1.
- `ras_ckpt_o` in cycle N is the state before cycle N's command. Recovering with it re-executes from a pre-bundle state.
- `ras_underflow_o`: high for exactly cycle N+1 after an empty pop in cycle N. It is suppressed if `recover_i` is high in cycle N.
- Back-to-back commands are accepted every cycle. There is no backpressure and no handshake beyond `ras_valid_i`.
- Wrap-around: tos wraps DEPTH-1 -> 0 on push and 0 -> DEPTH-1 on pop. Count saturates at DEPTH and floors at 0.

## Test plan
- **Reset:** assert `rst_i` asynchronously mid-cycle after 3 pushes -> outputs immediately read top=0, empty=1, ckpt=0. The next pop pulses `ras_underflow_o`.
- **Push/pop:** push pc 0x1000, then 0x2000 in consecutive cycles -> top = 0x2004, then the first pop gives top = 0x1004, the second pop gives empty = 1, and a third pop gives underflow pulse = 1 with count staying 0.
- **Overflow (DEPTH = 8):** push 9 PCs 0x100, 0x200, ... 0x900 -> count = 8, tos = 1 (wrapped). Then 8 pops return 0x904, 0x804, ... 0x204, then empty = 1; 0x104 is lost.
- **Coroutine:** from stack [0x1004], issue ctrl 11 with pc 0x3000 -> top = 0x3004, count = 1. From empty, ctrl 11 -> count = 1, no underflow.
- **Recovery:** capture ckpt after 2 pushes, then push 2 more and pop 1 -> recover with the saved ckpt gives count = 2, tos restored, top = second pushed value + 4. A push in the same cycle as recover is ignored.
- **Hold:** push with `ras_valid_i` = 0, and a valid command with ctrl = 00 -> no state change; ckpt is unchanged over 5 cycles.

Source files
------------

// File: rtl/ras_stack.sv
// Return address stack: push/pop/pop-then-push of return targets, with {count,tos} checkpoint and recover.
// State updates on the clock edge ending a command's cycle; no backpressure, one command per cycle.
module ras_stack #(
    parameter int DEPTH = 8,
    parameter int PW    = $clog2(DEPTH),
    parameter int CKW   = 2 * PW + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ras_valid_i,
    input  logic [1:0]      ras_ctrl_i,
    input  logic [63:0]     ras_pc_i,
    input  logic            recover_i,
    input  logic [CKW-1:0]  recover_ckpt_i,
    output logic [63:0]     ras_top_o,
    output logic            ras_empty_o,
    output logic [CKW-1:0]  ras_ckpt_o,
    output logic            ras_underflow_o
);

    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);
    localparam logic [PW:0] ONE  = (PW + 1)'(1);

    logic [63:0]   mem_q [DEPTH];
    logic [63:0]   mem_d [DEPTH];
    logic [PW-1:0] tos_q, tos_d;
    logic [PW:0]   count_q, count_d;
    logic          underflow_q, underflow_d;

    logic [PW-1:0] tos_inc;
    logic [63:0]   push_val;

    assign tos_inc  = tos_q + 1'b1;
    assign push_val = ras_pc_i + 64'd4;

    always_comb begin
        mem_d       = mem_q;
        tos_d       = tos_q;
        count_d     = count_q;
        underflow_d = 1'b0;
        if (recover_i) begin
            // Only pointers are restored; wrong-path memory writes are kept.
            count_d = recover_ckpt_i[CKW-1:PW];
            tos_d   = recover_ckpt_i[PW-1:0];
        end else if (ras_valid_i) begin
            case (ras_ctrl_i)
                2'b01: begin
                    mem_d[tos_inc] = push_val;
                    tos_d          = tos_inc;
                    if (count_q != FULL) begin
                        count_d = count_q + 1'b1;
                    end
                end
                2'b10: begin
                    if (count_q != '0) begin
                        tos_d   = tos_q - 1'b1;
                        count_d = count_q - 1'b1;
                    end else begin
                        underflow_d = 1'b1;
                    end
                end
                2'b11: begin
                    mem_d[tos_q] = push_val;
                    if (count_q == '0) begin
                        count_d = ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            tos_q       <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            tos_q       <= tos_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    assign ras_top_o       = mem_q[tos_q];
    assign ras_empty_o     = (count_q == '0);
    assign ras_ckpt_o      = {count_q, tos_q};
    assign ras_underflow_o = underflow_q;

endmodule
